tick_stopwatch: RTL and testbench
=================================

# tick_stopwatch

Stopwatch stage that consumes the one-cycle `tick` strobe produced by the upstream interval timer and turns it into an MM:SS display count in BCD. A prescaler accumulates ticks into seconds; cascaded BCD digits advance seconds and minutes. Start/stop/clear/lap commands drive a three-state controller. The outputs feed the seven-segment display multiplexer downstream.

## Interface
- `TICKS_PER_SEC`, 100, number of `tick` strobes per one-second advance (≥2)
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `tick`  in  1  one-cycle strobe from the upstream timer
- `start`  in  1  command: begin or resume counting (level, sampled each cycle)
- `stop`  in  1  command: pause counting
- `clear`  in  1  command: return to zero and idle
- `lap`  in  1  command: capture the current time into the lap registers
- `sec_ones`  out  4  BCD seconds units, 0–9
- `sec_tens`  out  4  BCD seconds tens, 0–5
- `min_ones`  out  4  BCD minutes units, 0–9
- `min_tens`  out  4  BCD minutes tens, 0–5
- `lap_time`  out  16  captured {min_tens, min_ones, sec_tens, sec_ones}
- `lap_valid`  out  1  one-cycle pulse; `lap_time` updated this cycle
- `running`  out  1  high while in RUN
- `wrap`  out  1  one-cycle pulse on rollover from 59:59 to 00:00

## Operation
- States: IDLE (all digits 0), RUN (counting), PAUSE (frozen, digits held).
- Command priority within one cycle: clear > stop > start; `lap` is independent of the others.
- IDLE: start → RUN; stop is ignored.
- RUN: clear → IDLE; stop → PAUSE; start is ignored.
- PAUSE: clear → IDLE; start → RUN; stop is ignored.
- clear in any state zeroes the digits, the prescaler and `lap_time`.
- Prescaler width: `$clog2(TICKS_PER_SEC)`. In RUN, each `tick` increments the prescaler. A `tick` seen while the prescaler equals TICKS_PER_SEC-1 resets the prescaler to 0 and advances the seconds by 1.
- Digit cascade:
  - sec_ones wraps 9→0 and carries into sec_tens.
  - sec_tens wraps 5→0 and carries into min_ones.
  - min_ones wraps 9→0 and carries into min_tens.
  - min_tens wraps 5→0 and asserts `wrap`.
- The prescaler is retained across PAUSE, so a resume continues the partial second.
- `lap` (any state other than a same-cycle clear) loads `lap_time` with the current pre-edge digits and pulses `lap_valid`. Lap does not affect counting.
- Digits never leave their BCD ranges. An illegal value is unreachable from reset.

## Timing
- Reset values: all digits 0, prescaler 0, `lap_time` 0, `lap_valid` 0, `running` 0, `wrap` 0, state IDLE.
- Reset takes priority over every input.
- All outputs are registered. A digit change is visible the cycle after the qualifying `tick` edge.
- A `tick` is counted only if the registered state is RUN at that edge:
  - start+tick in IDLE or PAUSE: tick not counted.
  - stop+tick in RUN: tick counted, then PAUSE.
  - clear+tick: clear wins; the tick is dropped.
- `running` goes high the cycle after the start edge and low the cycle after the stop or clear edge.
- `wrap` is high for exactly the cycle in which the digits show 00:00 after 59:59.
- `lap` + clear in the same cycle: clear wins; `lap_valid` is 0.
- Consecutive `lap` cycles each produce a pulse.

## Structure
- Package `stopwatch_pkg`:
  - state enum {IDLE, RUN, PAUSE}
  - `BCD_W` = 4
  - `LAP_W` = 16
  - digit limit constants 9 and 5
- Sub-module `bcd_digit_counter`:
  - parameter `LIMIT`
  - inputs: `clk`, `reset`, `clr`, `inc`
  - outputs: `digit` [3:0], `carry` (combinational: `inc` && digit==LIMIT)
  - instantiated four times in a carry chain.
- Controller and prescaler live in the top level.

## Test plan
- All tests use `TICKS_PER_SEC`=2.
- Reset: assert `reset` for 2 cycles mid-RUN at 00:07 → next cycle all digits 0, `running`=0, state IDLE; ticks are ignored until start.
- Start, then 20 ticks → 00:10 with sec_tens=1 and sec_ones=0; `running`=1 from the cycle after start.
- Pause/resume: stop after 3 ticks (00:01, prescaler 1); apply 5 ticks while paused → unchanged; start, then 1 tick → 00:02.
- Wrap: preload by running to 59:58, then 4 ticks → 00:00 with `wrap` high for one cycle; the count then continues to 00:01 after 2 more ticks.
- Simultaneous commands:
  - clear+stop+start in RUN → IDLE, zeros.
  - start+tick in IDLE → 00:00, prescaler 0.
  - stop+tick in RUN at prescaler 1 → seconds advance, then PAUSE.
- Lap: at 01:23, `lap` → `lap_time`=16'h0123 and `lap_valid` high for 1 cycle while counting continues; lap+clear → `lap_valid`=0 and `lap_time`=0.

Source files
------------

// File: rtl/tick_stopwatch_pkg.sv
// Shared types and constants for the tick-driven MM:SS stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int BCD_W       = 4;
    localparam int LAP_W       = 16;
    localparam int UNITS_LIMIT = 9;
    localparam int TENS_LIMIT  = 5;

endpackage

// File: rtl/tick_stopwatch_if.sv
// Command and display bundle between the stopwatch and its neighbours.
interface tick_stopwatch_if;
    import stopwatch_pkg::*;

    logic             tick;
    logic             start;
    logic             stop;
    logic             clear;
    logic             lap;
    logic [BCD_W-1:0] sec_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] min_tens;
    logic [LAP_W-1:0] lap_time;
    logic             lap_valid;
    logic             running;
    logic             wrap;

    modport master (
        output tick, start, stop, clear, lap,
        input  sec_ones, sec_tens, min_ones, min_tens,
        input  lap_time, lap_valid, running, wrap
    );

    modport slave (
        input  tick, start, stop, clear, lap,
        output sec_ones, sec_tens, min_ones, min_tens,
        output lap_time, lap_valid, running, wrap
    );

endinterface

// File: rtl/tick_stopwatch_digit.sv
// One BCD digit that wraps at LIMIT; carry is combinational so a chain
// of these advances in a single cycle.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int LIMIT = UNITS_LIMIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] digit,
    output logic             carry
);

    localparam logic [BCD_W-1:0] LIM = BCD_W'(LIMIT);

    assign carry = inc && (digit == LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc) begin
            digit <= (digit == LIM) ? '0 : digit + BCD_W'(1);
        end
    end

endmodule

// File: rtl/tick_stopwatch.sv
// Stopwatch: tick prescaler, IDLE/RUN/PAUSE controller and a four-digit
// BCD cascade producing MM:SS, plus lap capture and a rollover pulse.
module tick_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic             clk,
    input  logic             reset,
    tick_stopwatch_if.slave  sw
);

    localparam int PS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_SEC - 1);

    state_t          state;
    state_t          state_nxt;
    logic [PS_W-1:0] presc;
    logic            count_en;
    logic            sec_adv;
    logic            carry_so;
    logic            carry_st;
    logic            carry_mo;
    logic            carry_mt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (sw.clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (sw.start) state_nxt = RUN;
                RUN:     if (sw.stop)  state_nxt = PAUSE;
                PAUSE:   if (sw.start) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A tick counts only against the registered state, and clear drops it.
    always_comb begin
        count_en = (state == RUN) && sw.tick && !sw.clear;
        sec_adv  = count_en && (presc == PS_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc      <= '0;
            sw.running <= 1'b0;
        end else begin
            sw.running <= (state_nxt == RUN);
            if (sw.clear) begin
                presc <= '0;
            end else if (count_en) begin
                presc <= sec_adv ? '0 : presc + PS_W'(1);
            end
        end
    end

    bcd_digit_counter #(.LIMIT(UNITS_LIMIT)) u_sec_ones (
        .clk(clk), .reset(reset), .clr(sw.clear), .inc(sec_adv),
        .digit(sw.sec_ones), .carry(carry_so)
    );

    bcd_digit_counter #(.LIMIT(TENS_LIMIT)) u_sec_tens (
        .clk(clk), .reset(reset), .clr(sw.clear), .inc(carry_so),
        .digit(sw.sec_tens), .carry(carry_st)
    );

    bcd_digit_counter #(.LIMIT(UNITS_LIMIT)) u_min_ones (
        .clk(clk), .reset(reset), .clr(sw.clear), .inc(carry_st),
        .digit(sw.min_ones), .carry(carry_mo)
    );

    bcd_digit_counter #(.LIMIT(TENS_LIMIT)) u_min_tens (
        .clk(clk), .reset(reset), .clr(sw.clear), .inc(carry_mo),
        .digit(sw.min_tens), .carry(carry_mt)
    );

    // Lap samples the digits as they stand before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw.wrap      <= 1'b0;
            sw.lap_valid <= 1'b0;
            sw.lap_time  <= '0;
        end else if (sw.clear) begin
            sw.wrap      <= 1'b0;
            sw.lap_valid <= 1'b0;
            sw.lap_time  <= '0;
        end else begin
            sw.wrap      <= carry_mt;
            sw.lap_valid <= sw.lap;
            if (sw.lap) begin
                sw.lap_time <= {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones};
            end
        end
    end

endmodule

// File: tb/tb_tick_stopwatch.sv
// Bench for tick_stopwatch: behavioural seconds model feeding a scoreboard,
// a fixed vector table, and hand-written multi-cycle sequences.
module tb_tick_stopwatch;
    import stopwatch_pkg::*;

    localparam int TPS = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tick_stopwatch_if sw();

    tick_stopwatch #(.TICKS_PER_SEC(TPS)) dut (
        .clk(clk),
        .reset(reset),
        .sw(sw)
    );

    typedef struct {
        logic [15:0] t;
        logic [15:0] lt;
        logic        lv;
        logic        run;
        logic        wr;
    } exp_t;

    typedef struct {
        logic        r, tk, st, sp, cl, lp;
        logic [15:0] t;
        logic [15:0] lt;
        logic        lv;
        logic        run;
        logic        wr;
    } vec_t;

    exp_t   sb[$];
    int     total = 0;
    int     bad   = 0;

    int     m_secs  = 0;
    int     m_presc = 0;
    state_t m_st    = IDLE;
    logic [15:0] m_lt = '0;
    logic   m_lv = 1'b0;
    logic   m_wr = 1'b0;

    function automatic logic [15:0] to_bcd(input int s);
        logic [15:0] r;
        int m;
        int ss;
        m  = s / 60;
        ss = s % 60;
        r[15:12] = 4'(m / 10);
        r[11:8]  = 4'(m % 10);
        r[7:4]   = 4'(ss / 10);
        r[3:0]   = 4'(ss % 10);
        return r;
    endfunction

    function automatic logic [15:0] dut_time();
        return {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic r, tk, st, sp, cl, lp);
        logic [15:0] pre;
        pre = to_bcd(m_secs);
        if (r) begin
            m_secs = 0; m_presc = 0; m_st = IDLE; m_lt = '0; m_lv = 0; m_wr = 0;
        end else if (cl) begin
            m_secs = 0; m_presc = 0; m_st = IDLE; m_lt = '0; m_lv = 0; m_wr = 0;
        end else begin
            m_wr = 1'b0;
            if (m_st == RUN && tk) begin
                if (m_presc == TPS - 1) begin
                    m_presc = 0;
                    if (m_secs == 3599) begin
                        m_secs = 0;
                        m_wr   = 1'b1;
                    end else begin
                        m_secs++;
                    end
                end else begin
                    m_presc++;
                end
            end
            m_lv = lp;
            if (lp) m_lt = pre;
            if (m_st == RUN && sp) m_st = PAUSE;
            else if (m_st != RUN && st) m_st = RUN;
        end
    endtask

    task automatic step(input logic r, tk, st, sp, cl, lp);
        exp_t e;
        reset    = r;
        sw.tick  = tk;
        sw.start = st;
        sw.stop  = sp;
        sw.clear = cl;
        sw.lap   = lp;
        model(r, tk, st, sp, cl, lp);
        sb.push_back('{t: to_bcd(m_secs), lt: m_lt, lv: m_lv, run: (m_st == RUN), wr: m_wr});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_time",      dut_time(),          e.t);
        chk("sb_lap_time",  sw.lap_time,         e.lt);
        chk("sb_lap_valid", 16'(sw.lap_valid),   16'(e.lv));
        chk("sb_running",   16'(sw.running),     16'(e.run));
        chk("sb_wrap",      16'(sw.wrap),        16'(e.wr));
    endtask

    task automatic ticks(input int n);
        repeat (n) step(0, 1, 0, 0, 0, 0);
    endtask

    task automatic expect_now(input string name, input logic [15:0] t, input logic run);
        chk(name, dut_time(), t);
        chk({name, "_running"}, 16'(sw.running), 16'(run));
    endtask

    vec_t vt[14];

    initial begin
        // r  tk st sp cl lp  time      lap_time  lv run wr
        vt[0]  = '{1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0};
        vt[1]  = '{0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0};
        vt[2]  = '{0, 1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0};
        vt[3]  = '{0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0};
        vt[4]  = '{0, 1, 0, 0, 0, 0, 16'h0001, 16'h0000, 0, 1, 0};
        vt[5]  = '{0, 1, 0, 0, 0, 0, 16'h0001, 16'h0000, 0, 1, 0};
        vt[6]  = '{0, 1, 0, 1, 0, 0, 16'h0002, 16'h0000, 0, 0, 0};
        vt[7]  = '{0, 1, 0, 0, 0, 0, 16'h0002, 16'h0000, 0, 0, 0};
        vt[8]  = '{0, 0, 1, 0, 0, 0, 16'h0002, 16'h0000, 0, 1, 0};
        vt[9]  = '{0, 1, 0, 0, 0, 0, 16'h0002, 16'h0000, 0, 1, 0};
        vt[10] = '{0, 0, 0, 0, 0, 1, 16'h0002, 16'h0002, 1, 1, 0};
        vt[11] = '{0, 1, 0, 0, 0, 1, 16'h0003, 16'h0002, 1, 1, 0};
        vt[12] = '{0, 1, 1, 1, 1, 0, 16'h0000, 16'h0000, 0, 0, 0};
        vt[13] = '{0, 0, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 0, 0};

        reset = 1'b1;
        sw.tick = 0; sw.start = 0; sw.stop = 0; sw.clear = 0; sw.lap = 0;
        step(1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 14; i++) begin
            step(vt[i].r, vt[i].tk, vt[i].st, vt[i].sp, vt[i].cl, vt[i].lp);
            chk($sformatf("vec%0d_time", i),      dut_time(),        vt[i].t);
            chk($sformatf("vec%0d_lap_time", i),  sw.lap_time,       vt[i].lt);
            chk($sformatf("vec%0d_lap_valid", i), 16'(sw.lap_valid), 16'(vt[i].lv));
            chk($sformatf("vec%0d_running", i),   16'(sw.running),   16'(vt[i].run));
            chk($sformatf("vec%0d_wrap", i),      16'(sw.wrap),      16'(vt[i].wr));
        end

        // Twenty ticks make ten seconds.
        step(0, 0, 1, 0, 0, 0);
        expect_now("start_run", 16'h0000, 1'b1);
        ticks(20);
        expect_now("ten_seconds", 16'h0010, 1'b1);

        // Pause keeps the partial second.
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0);
        ticks(3);
        expect_now("before_pause", 16'h0001, 1'b1);
        step(0, 0, 0, 1, 0, 0);
        ticks(5);
        expect_now("paused_hold", 16'h0001, 1'b0);
        step(0, 0, 1, 0, 0, 0);
        ticks(1);
        expect_now("resume_partial", 16'h0002, 1'b1);

        // Reset mid-run at 00:07.
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0);
        ticks(14);
        expect_now("pre_reset", 16'h0007, 1'b1);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        expect_now("after_reset", 16'h0000, 1'b0);
        chk("after_reset_lap", sw.lap_time, 16'h0000);
        ticks(4);
        expect_now("idle_ticks_ignored", 16'h0000, 1'b0);

        // Rollover from 59:59.
        step(0, 0, 1, 0, 0, 0);
        ticks(7196);
        expect_now("at_5958", 16'h5958, 1'b1);
        ticks(3);
        expect_now("at_5959", 16'h5959, 1'b1);
        chk("wrap_low_before", 16'(sw.wrap), 16'h0);
        ticks(1);
        expect_now("wrapped", 16'h0000, 1'b1);
        chk("wrap_pulse", 16'(sw.wrap), 16'h1);
        ticks(1);
        chk("wrap_one_cycle", 16'(sw.wrap), 16'h0);
        ticks(1);
        expect_now("after_wrap", 16'h0001, 1'b1);

        // Lap at 01:23 while counting.
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0);
        ticks(166);
        expect_now("at_0123", 16'h0123, 1'b1);
        step(0, 1, 0, 0, 0, 1);
        chk("lap_capture", sw.lap_time, 16'h0123);
        chk("lap_pulse", 16'(sw.lap_valid), 16'h1);
        ticks(1);
        expect_now("lap_keeps_counting", 16'h0124, 1'b1);
        chk("lap_pulse_end", 16'(sw.lap_valid), 16'h0);
        step(0, 0, 0, 0, 1, 1);
        chk("lap_clear_valid", 16'(sw.lap_valid), 16'h0);
        chk("lap_clear_time", sw.lap_time, 16'h0000);
        expect_now("lap_clear_idle", 16'h0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
